// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory controller: DEPTH x 32-bit words behind a valid/ready
// request port, with programmable access latency, sub-word access and error reporting.
module data_memory_ctrl #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_error,
   output logic        busy
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          write_q, write_d;
   logic [31:0]   addr_q, addr_d;
   logic [1:0]    size_q, size_d;
   logic          uns_q, uns_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          error_q, error_d;
   logic [31:0]   mem_q [DEPTH];

   // With LATENCY==0 the access happens on the acceptance edge, so it must see the
   // live request; otherwise it uses the latched copy.
   logic          a_write, a_uns, a_err, do_acc, mem_we;
   logic [31:0]   a_addr, a_wdata, rd_word, wr_word, ld_val;
   logic [1:0]    a_size, a_lane;
   logic [AW-1:0] a_idx;
   logic [7:0]    ld_byte;
   logic [15:0]   ld_half;

   always_comb begin
      if (state_q == S_IDLE) begin
         a_write = req_write;
         a_addr  = req_addr;
         a_size  = req_size;
         a_uns   = req_unsigned;
         a_wdata = req_wdata;
      end else begin
         a_write = write_q;
         a_addr  = addr_q;
         a_size  = size_q;
         a_uns   = uns_q;
         a_wdata = wdata_q;
      end
      a_idx   = a_addr[AW+1:2];
      a_lane  = a_addr[1:0];
      a_err   = (a_size == 2'b11) ||
                (a_size == 2'b01 && a_addr[0]) ||
                (a_size == 2'b10 && a_lane != 2'b00) ||
                ((a_addr >> (AW + 2)) != 32'd0);
      rd_word = mem_q[a_idx];

      case (a_lane)
         2'd0:    ld_byte = rd_word[7:0];
         2'd1:    ld_byte = rd_word[15:8];
         2'd2:    ld_byte = rd_word[23:16];
         default: ld_byte = rd_word[31:24];
      endcase
      ld_half = a_addr[1] ? rd_word[31:16] : rd_word[15:0];

      case (a_size)
         2'b00:   ld_val = {{24{ld_byte[7] & ~a_uns}}, ld_byte};
         2'b01:   ld_val = {{16{ld_half[15] & ~a_uns}}, ld_half};
         default: ld_val = rd_word;
      endcase

      // Store merge keeps the unselected bytes of the current word.
      wr_word = rd_word;
      case (a_size)
         2'b00: begin
            case (a_lane)
               2'd0:    wr_word[7:0]   = a_wdata[7:0];
               2'd1:    wr_word[15:8]  = a_wdata[7:0];
               2'd2:    wr_word[23:16] = a_wdata[7:0];
               default: wr_word[31:24] = a_wdata[7:0];
            endcase
         end
         2'b01: begin
            if (a_addr[1]) wr_word[31:16] = a_wdata[15:0];
            else           wr_word[15:0]  = a_wdata[15:0];
         end
         default: wr_word = a_wdata;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      size_d  = size_q;
      uns_d   = uns_q;
      wdata_d = wdata_q;
      rdata_d = 32'd0;
      error_d = 1'b0;
      do_acc  = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               addr_d  = req_addr;
               size_d  = req_size;
               uns_d   = req_unsigned;
               wdata_d = req_wdata;
               if (LATENCY == 0) begin
                  do_acc  = 1'b1;
                  state_d = S_RESP;
               end else begin
                  cnt_d   = LAT_M1;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               do_acc  = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (do_acc) begin
         error_d = a_err;
         if (!a_err) begin
            if (a_write) mem_we  = 1'b1;
            else         rdata_d = ld_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         write_q <= 1'b0;
         addr_q  <= 32'd0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
         error_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
         if (mem_we) mem_q[a_idx] <= wr_word;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);
   assign rsp_rdata = rdata_q;
   assign rsp_error = error_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: instance a uses LATENCY=1, instance b LATENCY=0.
module tb_data_memory_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rv_a = 1'b0, rv_b = 1'b0;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [1:0]  req_size = 2'b10;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = 32'd0;
   logic        rdy_a, rvld_a, rerr_a, busy_a;
   logic        rdy_b, rvld_b, rerr_b, busy_b;
   logic [31:0] rdat_a, rdat_b;

   int vec = 0;
   int errs = 0;

   always #5 clk = ~clk;

   data_memory_ctrl #(.DEPTH(64), .LATENCY(1)) u_a (
      .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(rdy_a),
      .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_wdata(req_wdata),
      .rsp_valid(rvld_a), .rsp_rdata(rdat_a), .rsp_error(rerr_a), .busy(busy_a));

   data_memory_ctrl #(.DEPTH(64), .LATENCY(0)) u_b (
      .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(rdy_b),
      .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
      .req_unsigned(req_unsigned), .req_wdata(req_wdata),
      .rsp_valid(rvld_b), .rsp_rdata(rdat_b), .rsp_error(rerr_b), .busy(busy_b));

   // One request; inputs are scrambled right after acceptance so a design that
   // reads the live port instead of its latched copy misbehaves. Observes 6 cycles.
   task automatic txn(input bit sel, input bit wr, input logic [31:0] addr,
                      input logic [1:0] sz, input bit uns, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat,
                      output int rlow, output int pulses, output int bhi);
      @(negedge clk);
      req_write = wr; req_addr = addr; req_size = sz; req_unsigned = uns; req_wdata = wd;
      if (sel) rv_b = 1'b1; else rv_a = 1'b1;
      @(posedge clk); #1;
      rv_a = 1'b0; rv_b = 1'b0;
      req_write = ~wr; req_addr = 32'h0000_000C; req_size = 2'b10;
      req_unsigned = ~uns; req_wdata = 32'hFFFF_FFFF;
      lat = 99; rlow = 0; pulses = 0; bhi = 0; rd = 32'hBAD0_BAD0; er = 1'b1;
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         if (!(sel ? rdy_b : rdy_a)) rlow++;
         if (sel ? busy_b : busy_a) bhi++;
         if (sel ? rvld_b : rvld_a) begin
            pulses++;
            if (lat == 99) begin
               lat = n;
               rd  = sel ? rdat_b : rdat_a;
               er  = sel ? rerr_b : rerr_a;
            end
         end
      end
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat, rlow, pulses, bhi;

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      vec++;
      if ({rdy_a, rvld_a, rerr_a, busy_a, rdat_a} !== {4'b1000, 32'd0}) begin
         errs++; $display("FAIL reset_a rdy/vld/err/busy/rdata=%b%b%b%b/%h want 1000/0", rdy_a, rvld_a, rerr_a, busy_a, rdat_a);
      end
      vec++;
      if ({rdy_b, rvld_b, rerr_b, busy_b, rdat_b} !== {4'b1000, 32'd0}) begin
         errs++; $display("FAIL reset_b rdy/vld/err/busy/rdata=%b%b%b%b/%h want 1000/0", rdy_b, rvld_b, rerr_b, busy_b, rdat_b);
      end
      reset = 1'b1;
      txn(0, 0, 32'h20, 2'b10, 0, 0, rd, er, lat, rlow, pulses, bhi);
      vec++;
      if ({er, rd} !== 33'd0) begin
         errs++; $display("FAIL reset_mem_clear got err=%b data=%h want err=0 data=00000000", er, rd);
      end
   endtask

   task automatic test_word();
      txn(0, 1, 32'h08, 2'b10, 0, 32'hDEADBEEF, rd, er, lat, rlow, pulses, bhi);
      vec++;
      if (lat !== 2 || rlow !== 2 || pulses !== 1 || bhi !== 2) begin
         errs++; $display("FAIL sw_timing lat=%0d rdylow=%0d pulses=%0d busy=%0d want 2/2/1/2", lat, rlow, pulses, bhi);
      end
      vec++;
      if ({er, rd} !== 33'd0) begin
         errs++; $display("FAIL sw_rsp got err=%b data=%h want 0/00000000", er, rd);
      end
      txn(0, 0, 32'h08, 2'b10, 1, 0, rd, er, lat, rlow, pulses, bhi);
      vec++;
      if (lat !== 2 || rlow !== 2 || pulses !== 1) begin
         errs++; $display("FAIL lw_timing lat=%0d rdylow=%0d pulses=%0d want 2/2/1", lat, rlow, pulses);
      end
      vec++;
      if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin
         errs++; $display("FAIL lw_data got err=%b data=%h want 0/deadbeef", er, rd);
      end
   endtask

   task automatic test_subword_store();
      txn(0, 1, 32'h09, 2'b00, 0, 32'hAAAAAA11, rd, er, lat, rlow, pulses, bhi);
      txn(0, 0, 32'h08, 2'b10, 0, 0, rd, er, lat, rlow, pulses, bhi);
      vec++;
      if ({er, rd} !== {1'b0, 32'hDEAD11EF}) begin
         errs++; $display("FAIL sb_merge got err=%b data=%h want 0/dead11ef", er, rd);
      end
      txn(0, 1, 32'h0A, 2'b01, 0, 32'hBBBB1234, rd, er, lat, rlow, pulses, bhi);
      txn(0, 0, 32'h08, 2'b10, 0, 0, rd, er, lat, rlow, pulses, bhi);
      vec++;
      if ({er, rd} !== {1'b0, 32'h123411EF}) begin
         errs++; $display("FAIL sh_merge got err=%b data=%h want 0/123411ef", er, rd);
      end
   endtask

   task automatic test_loads();
      logic [31:0] a_tab [5] = '{32'h08, 32'h08, 32'h09, 32'h0A, 32'h0A};
      logic [1:0]  s_tab [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
      bit          u_tab [5] = '{0, 1, 0, 0, 1};
      logic [31:0] e_tab [5] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F,
                                 32'hFFFF8081, 32'h00008081};
      txn(0, 1, 32'h08, 2'b10, 0, 32'h80817F80, rd, er, lat, rlow, pulses, bhi);
      for (int i = 0; i < 5; i++) begin
         txn(0, 0, a_tab[i], s_tab[i], u_tab[i], 0, rd, er, lat, rlow, pulses, bhi);
         vec++;
         if ({er, rd} !== {1'b0, e_tab[i]}) begin
            errs++; $display("FAIL load_%0d addr=%h size=%b uns=%0d got err=%b data=%h want 0/%h",
                             i, a_tab[i], s_tab[i], u_tab[i], er, rd, e_tab[i]);
         end
      end
   endtask

   task automatic test_errors();
      logic [31:0] a_tab [5] = '{32'h02, 32'h05, 32'h08, 32'h100, 32'h09};
      logic [1:0]  s_tab [5] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01};
      bit          w_tab [5] = '{0, 0, 0, 1, 1};
      txn(0, 1, 32'h00, 2'b10, 0, 32'h01020304, rd, er, lat, rlow, pulses, bhi);
      for (int i = 0; i < 5; i++) begin
         txn(0, w_tab[i], a_tab[i], s_tab[i], 0, 32'hCAFEBABE, rd, er, lat, rlow, pulses, bhi);
         vec++;
         if ({er, rd} !== {1'b1, 32'd0} || lat !== 2 || pulses !== 1) begin
            errs++; $display("FAIL err_%0d addr=%h size=%b got err=%b data=%h lat=%0d want 1/00000000 lat=2",
                             i, a_tab[i], s_tab[i], er, rd, lat);
         end
      end
      txn(0, 0, 32'h00, 2'b10, 0, 0, rd, er, lat, rlow, pulses, bhi);
      vec++;
      if ({er, rd} !== {1'b0, 32'h01020304}) begin
         errs++; $display("FAIL err_oor_nowrite got err=%b data=%h want 0/01020304", er, rd);
      end
      txn(0, 0, 32'h08, 2'b10, 0, 0, rd, er, lat, rlow, pulses, bhi);
      vec++;
      if ({er, rd} !== {1'b0, 32'h80817F80}) begin
         errs++; $display("FAIL err_mis_nowrite got err=%b data=%h want 0/80817f80", er, rd);
      end
   endtask

   task automatic test_lat0();
      logic [7:0] rdy_bits, vld_bits;
      bit         data_ok;
      txn(1, 1, 32'h08, 2'b10, 0, 32'h55AA33CC, rd, er, lat, rlow, pulses, bhi);
      vec++;
      if (lat !== 1 || rlow !== 1 || pulses !== 1 || bhi !== 1) begin
         errs++; $display("FAIL lat0_timing lat=%0d rdylow=%0d pulses=%0d busy=%0d want 1/1/1/1", lat, rlow, pulses, bhi);
      end
      txn(1, 0, 32'h0B, 2'b00, 0, 0, rd, er, lat, rlow, pulses, bhi);
      vec++;
      if ({er, rd} !== {1'b0, 32'h00000055} || lat !== 1) begin
         errs++; $display("FAIL lat0_lb got err=%b data=%h lat=%0d want 0/00000055 lat=1", er, rd, lat);
      end
      // Back-to-back: valid held high, acceptance only every second cycle.
      @(negedge clk);
      req_write = 1'b0; req_addr = 32'h08; req_size = 2'b10; req_unsigned = 1'b0;
      rv_b = 1'b1;
      rdy_bits = '0; vld_bits = '0; data_ok = 1'b1;
      for (int n = 0; n < 8; n++) begin
         if (n > 0) @(negedge clk);
         rdy_bits[n] = rdy_b;
         vld_bits[n] = rvld_b;
         if (rvld_b && (rdat_b !== 32'h55AA33CC || rerr_b !== 1'b0)) data_ok = 1'b0;
      end
      rv_b = 1'b0;
      vec++;
      if (rdy_bits !== 8'h55) begin
         errs++; $display("FAIL b2b_ready pattern=%b want 01010101", rdy_bits);
      end
      vec++;
      if (vld_bits !== 8'hAA) begin
         errs++; $display("FAIL b2b_rsp pattern=%b want 10101010", vld_bits);
      end
      vec++;
      if (!data_ok) begin
         errs++; $display("FAIL b2b_data got a response other than 0/55aa33cc");
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_wait();
      bit saw_rsp;
      @(negedge clk);
      req_write = 1'b1; req_addr = 32'h10; req_size = 2'b10; req_wdata = 32'h77777777;
      rv_a = 1'b1;
      @(posedge clk); #1;
      rv_a = 1'b0;
      @(negedge clk);
      vec++;
      if (busy_a !== 1'b1) begin
         errs++; $display("FAIL rstwait_inwait busy=%b want 1", busy_a);
      end
      reset = 1'b0;
      @(negedge clk);
      saw_rsp = rvld_a;
      reset = 1'b1;
      @(negedge clk);
      saw_rsp = saw_rsp | rvld_a;
      vec++;
      if (rdy_a !== 1'b1 || saw_rsp) begin
         errs++; $display("FAIL rstwait_state ready=%b rsp_seen=%0d want 1/0", rdy_a, saw_rsp);
      end
      txn(0, 0, 32'h10, 2'b10, 0, 0, rd, er, lat, rlow, pulses, bhi);
      vec++;
      if ({er, rd} !== 33'd0) begin
         errs++; $display("FAIL rstwait_nowrite got err=%b data=%h want 0/00000000", er, rd);
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword_store();
      test_loads();
      test_errors();
      test_lat0();
      test_reset_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
